// File: rtl/shift_add_multiplier_if.sv
// Start/busy/done handshake and operand/product bus of the sequential
// shift-and-add multiplier. The requester drives "master", the multiplier implements "slave".
interface shift_add_multiplier_if #(
    parameter int dp_width = 5
);
    logic                      start;
    logic [dp_width-1:0]       multiplicand;
    logic [dp_width-1:0]       multiplier;
    logic                      busy;
    logic                      done;
    logic [2*dp_width-1:0]     product;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: one conditional-add and one shift cycle per
// multiplier bit. Define SHIFT_ADD_MULT_SIGNED_EN for two's-complement operands (sign-magnitude).
module shift_add_multiplier #(
    parameter int dp_width = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    shift_add_multiplier_if.slave  bus
);
    localparam int P_W = $clog2(dp_width + 1);
    localparam logic [P_W-1:0] P_LOAD = P_W'(dp_width);
    localparam logic [P_W-1:0] P_ONE  = P_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2
    } state_e;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    // Magnitude of a two's-complement operand; the most negative value maps onto 2^(dp_width-1).
    function automatic logic [dp_width-1:0] magnitude(input logic [dp_width-1:0] v);
        logic [dp_width-1:0] m;
        if (v[dp_width-1]) begin
            m = ~v + {{(dp_width-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction

    function automatic logic [2*dp_width-1:0] negate(input logic [2*dp_width-1:0] v);
        return ~v + {{(2*dp_width-1){1'b0}}, 1'b1};
    endfunction
`endif

    state_e                state_q, state_d;
    logic [dp_width-1:0]   a_q, a_d;
    logic [dp_width-1:0]   b_q, b_d;
    logic [dp_width-1:0]   q_q, q_d;
    logic                  c_q, c_d;
    logic [P_W-1:0]        p_q, p_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [2*dp_width-1:0] product_q, product_d;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    logic                  neg_q, neg_d;
`endif

    logic [dp_width:0]     sum_s;
    logic [2*dp_width:0]   shifted_s;
    logic [2*dp_width-1:0] result_s;

    // Datapath arithmetic: full-width add and the {C,A,Q} right shift with 0 entering C.
    always_comb begin
        sum_s     = {1'b0, a_q} + {1'b0, b_q};
        shifted_s = {1'b0, c_q, a_q, q_q[dp_width-1:1]};
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        if (neg_q) begin
            result_s = negate(shifted_s[2*dp_width-1:0]);
        end else begin
            result_s = shifted_s[2*dp_width-1:0];
        end
`else
        result_s = shifted_s[2*dp_width-1:0];
`endif
    end

    // Controller and register next-state: IDLE accepts, ADD conditionally adds, SHIFT shifts and counts.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        q_d       = q_q;
        c_d       = c_q;
        p_d       = p_q;
        done_d    = 1'b0;
        product_d = product_q;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        neg_d     = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifdef SHIFT_ADD_MULT_SIGNED_EN
                    b_d   = magnitude(bus.multiplicand);
                    q_d   = magnitude(bus.multiplier);
                    neg_d = bus.multiplicand[dp_width-1] ^ bus.multiplier[dp_width-1];
`else
                    b_d   = bus.multiplicand;
                    q_d   = bus.multiplier;
`endif
                    a_d     = {dp_width{1'b0}};
                    c_d     = 1'b0;
                    p_d     = P_LOAD;
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                if (q_q[0]) begin
                    {c_d, a_d} = sum_s;
                end else begin
                    c_d = c_q;
                    a_d = a_q;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                {c_d, a_d, q_d} = shifted_s;
                p_d             = p_q - P_ONE;
                if (p_q == P_ONE) begin
                    product_d = result_s;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d   = ADD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset; reset also aborts an operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= {dp_width{1'b0}};
            b_q       <= {dp_width{1'b0}};
            q_q       <= {dp_width{1'b0}};
            c_q       <= 1'b0;
            p_q       <= {P_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= {(2*dp_width){1'b0}};
`ifdef SHIFT_ADD_MULT_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            q_q       <= q_d;
            c_q       <= c_d;
            p_q       <= p_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier at dp_width=5 (unsigned by
// default; signed vectors when SHIFT_ADD_MULT_SIGNED_EN is defined).
module tb_shift_add_multiplier;
    localparam int W   = 5;
    localparam int LAT = 2 * W;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    localparam logic [2*W-1:0] P_23X19 = 10'd117;   // (-9) * (-13)
`else
    localparam logic [2*W-1:0] P_23X19 = 10'd437;
`endif

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    shift_add_multiplier_if #(.dp_width(W)) bus ();

    shift_add_multiplier #(.dp_width(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] mc, input logic [W-1:0] mp);
        bus.start        = 1'b1;
        bus.multiplicand = mc;
        bus.multiplier   = mp;
        step();
        bus.start        = 1'b0;
    endtask

    // Runs edges 1..LAT after an accept; optionally re-pulses start (3x3) before edge repulse_k.
    task automatic run_body(input string tag, input logic [2*W-1:0] exp,
                            input logic [2*W-1:0] prev, input int repulse_k);
        int busy_cnt;
        int early_done;
        int held;
        busy_cnt   = 0;
        early_done = 0;
        held       = 0;
        for (int k = 1; k <= LAT; k++) begin
            if (k == repulse_k) begin
                bus.start        = 1'b1;
                bus.multiplicand = 5'd3;
                bus.multiplier   = 5'd3;
            end else begin
                bus.start        = 1'b0;
            end
            step();
            if (k < LAT) begin
                if (bus.busy === 1'b1) busy_cnt++;
                if (bus.done !== 1'b0) early_done++;
                if (bus.product === prev) held++;
            end
        end
        bus.start = 1'b0;
        check_eq({tag, "_busy_cycles"}, busy_cnt, LAT - 1);
        check_eq({tag, "_early_done"}, early_done, 0);
        check_eq({tag, "_prod_held"}, held, LAT - 1);
        check_eq({tag, "_done"}, bus.done, 1'b1);
        check_eq({tag, "_busy_at_done"}, bus.busy, 1'b0);
        check_eq({tag, "_product"}, bus.product, exp);
    endtask

    task automatic after_done(input string tag, input logic [2*W-1:0] exp);
        step();
        check_eq({tag, "_done_width"}, bus.done, 1'b0);
        check_eq({tag, "_prod_hold"}, bus.product, exp);
    endtask

    initial begin
        int dones;
        int done_at [3];
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = 5'd0;
        bus.multiplier   = 5'd0;
        step();
        step();
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_product", bus.product, 10'd0);
        reset = 1'b0;
        step();

`ifdef SHIFT_ADD_MULT_SIGNED_EN
        start_op(5'b11101, 5'd7);
        run_body("s_m3x7", 10'h3EB, 10'd0, 0);
        after_done("s_m3x7", 10'h3EB);
        start_op(5'b10000, 5'b10000);
        run_body("s_m16xm16", 10'd256, 10'h3EB, 0);
        after_done("s_m16xm16", 10'd256);
        start_op(5'b10000, 5'd1);
        run_body("s_m16x1", 10'h3F0, 10'd256, 0);
        after_done("s_m16x1", 10'h3F0);
        start_op(5'd0, 5'd25);
        run_body("s_0x25", 10'd0, 10'h3F0, 0);
        after_done("s_0x25", 10'd0);
`else
        start_op(5'd23, 5'd19);
        run_body("u_23x19", 10'd437, 10'd0, 0);
        after_done("u_23x19", 10'd437);
        start_op(5'd31, 5'd31);
        run_body("u_31x31", 10'd961, 10'd437, 0);
        after_done("u_31x31", 10'd961);
        start_op(5'd0, 5'd25);
        run_body("u_0x25", 10'd0, 10'd961, 0);
        after_done("u_0x25", 10'd0);
`endif

        // Start while busy is ignored; start in the done cycle is accepted.
        start_op(5'd23, 5'd19);
        run_body("busy_start", P_23X19, 10'd0, 4);
        start_op(5'd3, 5'd3);
        run_body("b2b_3x3", 10'd9, P_23X19, 0);
        after_done("b2b_3x3", 10'd9);

        // Reset in the middle of an operation aborts it.
        start_op(5'd23, 5'd19);
        for (int k = 1; k <= 4; k++) step();
        reset = 1'b1;
        step();
        check_eq("midrst_busy", bus.busy, 1'b0);
        check_eq("midrst_done", bus.done, 1'b0);
        check_eq("midrst_product", bus.product, 10'd0);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (bus.done === 1'b1) dones++;
        end
        check_eq("midrst_no_done", dones, 0);

        // Continuous start: one result every LAT+1 cycles.
        bus.start        = 1'b1;
        bus.multiplicand = 5'd23;
        bus.multiplier   = 5'd19;
        dones            = 0;
        for (int e = 0; e <= 3 * (LAT + 1) - 1; e++) begin
            step();
            if (bus.done === 1'b1) begin
                if (dones < 3) done_at[dones] = e;
                dones++;
            end
        end
        bus.start = 1'b0;
        check_eq("cont_done_count", dones, 3);
        check_eq("cont_done0", done_at[0], LAT);
        check_eq("cont_done1", done_at[1], 2 * LAT + 1);
        check_eq("cont_done2", done_at[2], 3 * LAT + 2);
        check_eq("cont_product", bus.product, P_23X19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
